// File: rtl/regfile_read_pipe.sv
// regfile_read_pipe: 32x32 register file with a registered, valid/ready flow-controlled dual read port
module regfile_read_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   input  logic                  ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0] data_writeReg,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] data_readRegA,
   output logic [DATA_WIDTH-1:0] data_readRegB,
   output logic [CNT_WIDTH-1:0]  read_count
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state_q;
   logic [DATA_WIDTH-1:0] regs_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] a_q, b_q, a_d, b_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic wr, accept, done;
   assign wr = ctrl_writeEnable && ctrl_writeReg != '0;
   assign resp_valid = state_q == FULL;
   assign req_ready = !resp_valid || resp_ready;
   assign accept = req_valid && req_ready;
   assign done = resp_valid && resp_ready;
   assign data_readRegA = a_q;
   assign data_readRegB = b_q;
   assign read_count = cnt_q;
   // operand select: hardwired zero, then same-cycle write bypass, then stored value
   always_comb begin
      a_d = ctrl_readRegA == '0 ? '0 : (wr && ctrl_writeReg == ctrl_readRegA) ? data_writeReg : regs_q[ctrl_readRegA];
      b_d = ctrl_readRegB == '0 ? '0 : (wr && ctrl_writeReg == ctrl_readRegB) ? data_writeReg : regs_q[ctrl_readRegB];
   end
   // register array; index 0 is never written so it stays zero
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < 2**ADDR_WIDTH; i++) regs_q[i] <= '0;
      end else if (wr) begin
         regs_q[ctrl_writeReg] <= data_writeReg;
      end
   end
   // response stage: EMPTY/FULL state, snapshot operand pair on accept, count completions
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state_q <= EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            state_q <= FULL;
            a_q     <= a_d;
            b_q     <= b_d;
         end else if (done) begin
            state_q <= EMPTY;
         end
         if (done) cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_read_pipe.sv
// tb_regfile_read_pipe: directed stimulus, per-cycle model comparison plus literal spot checks
module tb_regfile_read_pipe;
   logic clk = 0;
   logic rst, we, req_valid, resp_ready;
   logic [4:0] wreg, ra, rb;
   logic [31:0] wdata;
   logic req_ready, resp_valid, req_ready4, resp_valid4;
   logic [31:0] da, db, da4, db4;
   logic [15:0] cnt;
   logic [3:0] cnt4;
   int checks = 0, failures = 0;
   logic checking = 0;

   always #5 clk = ~clk;

   regfile_read_pipe dut (
      .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
      .data_writeReg(wdata), .req_valid(req_valid), .req_ready(req_ready),
      .ctrl_readRegA(ra), .ctrl_readRegB(rb), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .data_readRegA(da), .data_readRegB(db), .read_count(cnt)
   );

   regfile_read_pipe #(.CNT_WIDTH(4)) dut4 (
      .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
      .data_writeReg(wdata), .req_valid(req_valid), .req_ready(req_ready4),
      .ctrl_readRegA(ra), .ctrl_readRegB(rb), .resp_valid(resp_valid4),
      .resp_ready(resp_ready), .data_readRegA(da4), .data_readRegB(db4), .read_count(cnt4)
   );

   // behavioural model
   logic [31:0] mem [32];
   logic ev = 0;
   logic [31:0] ea = 0, eb = 0;
   int ecnt = 0;

   function automatic logic [31:0] rd(input logic [4:0] idx);
      if (idx == 0) return 0;
      if (we && wreg == idx) return wdata;
      return mem[idx];
   endfunction

   always @(posedge clk) begin
      logic acc, fin;
      if (rst) begin
         foreach (mem[i]) mem[i] = 0;
         ev = 0; ea = 0; eb = 0; ecnt = 0;
      end else begin
         acc = req_valid && (!ev || resp_ready);
         fin = ev && resp_ready;
         if (acc) begin ea = rd(ra); eb = rd(rb); end
         if (fin) ecnt++;
         ev = acc ? 1'b1 : (fin ? 1'b0 : ev);
         if (we && wreg != 0) mem[wreg] = wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process
   always @(negedge clk) begin
      if (checking) begin
         chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
         chk("req_ready", {31'b0, req_ready}, {31'b0, !ev || resp_ready});
         chk("data_a", da, ea);
         chk("data_b", db, eb);
         chk("read_count", {16'b0, cnt}, ecnt & 32'hFFFF);
         chk("resp_valid4", {31'b0, resp_valid4}, {31'b0, ev});
         chk("data_a4", da4, ea);
         chk("data_b4", db4, eb);
         chk("read_count4", {28'b0, cnt4}, ecnt & 32'hF);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1; tick; rst = 0;
   endtask

   initial begin
      rst = 1; we = 0; wreg = 0; wdata = 0; req_valid = 0; resp_ready = 0; ra = 0; rb = 0;
      tick; tick; rst = 0;
      checking = 1;
      chk("rst_valid", {31'b0, resp_valid}, 0);
      chk("rst_ready", {31'b0, req_ready}, 1);
      chk("rst_count", {16'b0, cnt}, 0);
      // idle read after reset
      req_valid = 1; resp_ready = 1; ra = 5; rb = 9; tick; req_valid = 0;
      chk("idle_valid", {31'b0, resp_valid}, 1);
      chk("idle_a", da, 0);
      chk("idle_b", db, 0);
      // write with same-cycle bypass
      we = 1; wreg = 7; wdata = 32'hDEADBEEF; req_valid = 1; ra = 7; rb = 7; tick;
      chk("byp_valid", {31'b0, resp_valid}, 1);
      chk("byp_a", da, 32'hDEADBEEF);
      chk("byp_b", db, 32'hDEADBEEF);
      wreg = 0; wdata = 32'h1234; ra = 0; rb = 7; tick;
      chk("r0_a", da, 0);
      chk("r0_b", db, 32'hDEADBEEF);
      we = 0; req_valid = 0; tick;
      chk("drain_valid", {31'b0, resp_valid}, 0);
      // backpressure snapshot
      we = 1; wreg = 3; wdata = 32'h11; tick;
      we = 0; req_valid = 1; ra = 3; rb = 3; resp_ready = 0; tick;
      chk("bp_valid", {31'b0, resp_valid}, 1);
      chk("bp_a0", da, 32'h11);
      for (int i = 0; i < 4; i++) begin
         we = 1; wreg = 3; wdata = 32'h22; req_valid = 1;
         chk("bp_ready", {31'b0, req_ready}, 0);
         tick;
         chk("bp_hold_a", da, 32'h11);
      end
      we = 0; resp_ready = 1; ra = 3; rb = 0; tick;
      chk("bp_new_a", da, 32'h22);
      chk("bp_new_b", db, 0);
      req_valid = 0; tick;
      // back-to-back after fresh reset
      do_reset;
      we = 1;
      for (int i = 1; i <= 4; i++) begin wreg = 5'(i); wdata = 32'(i * 16); tick; end
      we = 0; req_valid = 1; resp_ready = 1;
      ra = 1; rb = 2; tick;
      chk("b2b_a1", da, 32'h10); chk("b2b_b1", db, 32'h20);
      ra = 3; rb = 4; tick;
      chk("b2b_a2", da, 32'h30); chk("b2b_b2", db, 32'h40);
      ra = 2; rb = 1; tick;
      chk("b2b_a3", da, 32'h20); chk("b2b_b3", db, 32'h10);
      req_valid = 0; tick;
      chk("b2b_count", {16'b0, cnt}, 3);
      // reset in the middle of a held response
      do_reset;
      we = 1; wreg = 1; wdata = 32'h10; tick; we = 0;
      req_valid = 1; ra = 1; rb = 1; resp_ready = 0; tick;
      chk("mid_held_a", da, 32'h10);
      rst = 1; we = 1; wreg = 5; wdata = 32'h55; tick;
      rst = 0; we = 0; req_valid = 0;
      chk("mid_valid", {31'b0, resp_valid}, 0);
      chk("mid_a", da, 0);
      chk("mid_count", {16'b0, cnt}, 0);
      req_valid = 1; resp_ready = 1; ra = 1; rb = 5; tick; req_valid = 0;
      chk("mid_reg1", da, 0);
      chk("mid_reg5", db, 0);
      tick;
      // counter wrap on the narrow-counter instance
      do_reset;
      req_valid = 1; resp_ready = 1; ra = 0; rb = 0;
      for (int i = 0; i < 17; i++) tick;
      req_valid = 0; tick;
      chk("wrap_count4", {28'b0, cnt4}, 1);
      chk("wrap_count16", {16'b0, cnt}, 17);
      tick;
      checking = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
